// File: rtl/ss_pkg.sv
// Shared types and constants for the binary-to-BCD converter and the seven-segment display path.
package ss_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int unsigned BCD_MAX = 9999;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd_word_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } b2b_state_t;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_if.sv
// Start/busy/done handshake bundle between the sensor datapath and the BCD converter.
interface bin_to_bcd_if #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
);

  logic                  start;
  logic [BIN_WIDTH-1:0]  bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd_register;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, bcd_register
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, bcd_register
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import ss_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a saturated result held stable for the display multiplexer.
module bin_to_bcd
  import ss_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = BCD_DIGITS
) (
  input logic         clk,
  input logic         rst,
  bin_to_bcd_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam int BCD_W = 4 * DIGITS;
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);
  localparam logic [BCD_W-1:0] SATURATED = {DIGITS{4'h9}};

  b2b_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_WIDTH-1:0] shift;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adj;
  logic                 ovf_pend;
  logic                 done_q;
  logic                 overflow_q;
  logic [BCD_W-1:0]     bcd_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (scratch[4*i +: 4]),
      .digit_out (adj[4*i +: 4])
    );
  end

  // Overflow is decided on the raw input at accept time; bits lost off the top digit are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      scratch    <= '0;
      ovf_pend   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift    <= bus.bin_in;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= (32'(bus.bin_in) > MAX_VAL);
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= {adj[BCD_W-2:0], shift[BIN_WIDTH-1]};
          shift   <= {shift[BIN_WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_q      <= ovf_pend ? SATURATED : scratch;
          overflow_q <= ovf_pend;
          done_q     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;
  assign bus.bcd_register = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd: latency, saturation, handshake corner cases and a sampled sweep.
module tb_bin_to_bcd;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bin_to_bcd_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();

  bin_to_bcd #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] expected_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Called on a falling edge; returns on the falling edge right after the accept edge.
  task automatic launch(input int v);
    bus.bin_in = 14'(v);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles, output logic changed);
    logic [15:0] bcd0;
    bcd0        = bus.bcd_register;
    lat         = 0;
    busy_cycles = 0;
    changed     = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.bcd_register !== bcd0) changed = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b want 0", bus.overflow); end
    checks++;
    if (bus.bcd_register !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bcd got %h want 0000", bus.bcd_register); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, bc;
    logic ch;
    launch(0);
    wait_done(lat, bc, ch);
    checks++;
    if (lat !== 15) begin errors++; $display("[TB] FAIL zero_latency got %0d want 15", lat); end
    checks++;
    if (bc !== 15) begin errors++; $display("[TB] FAIL zero_busy_cycles got %0d want 15", bc); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_in_done got %b want 0", bus.busy); end
    checks++;
    if (bus.bcd_register !== 16'h0000 || bus.overflow !== 1'b0)
      begin errors++; $display("[TB] FAIL zero_value got %h/%b want 0000/0", bus.bcd_register, bus.overflow); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic ch;
    launch(3210);
    wait_done(lat, bc, ch);
    checks++;
    if (lat !== 15 || bus.bcd_register !== 16'h3210)
      begin errors++; $display("[TB] FAIL typical_3210 got %h lat %0d want 3210 lat 15", bus.bcd_register, lat); end
    // Restart in the done cycle itself
    launch(1234);
    wait_done(lat, bc, ch);
    checks++;
    if (lat !== 15 || bus.bcd_register !== 16'h1234 || bus.overflow !== 1'b0)
      begin errors++; $display("[TB] FAIL b2b_1234 got %h/%b lat %0d want 1234/0 lat 15", bus.bcd_register, bus.overflow, lat); end
    checks++;
    if (ch !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold got changed=%b want 0", ch); end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int lat, bc;
    logic ch;
    int vals[3] = '{9999, 10000, 16383};
    logic ovf[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      launch(vals[i]);
      wait_done(lat, bc, ch);
      checks++;
      if (lat !== 15 || bus.bcd_register !== 16'h9999 || bus.overflow !== ovf[i])
        begin errors++; $display("[TB] FAIL boundary_%0d got %h/%b lat %0d want 9999/%b lat 15", vals[i], bus.bcd_register, bus.overflow, lat, ovf[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc, ndone, nbusy;
    logic ch;
    launch(42);
    repeat (5) @(negedge clk);
    bus.bin_in = 14'd7777;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done(lat, bc, ch);
    checks++;
    if (lat + 6 !== 15 || bus.bcd_register !== 16'h0042 || bus.overflow !== 1'b0)
      begin errors++; $display("[TB] FAIL busy_start got %h/%b lat %0d want 0042/0 lat 15", bus.bcd_register, bus.overflow, lat + 6); end
    ndone = 0;
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) nbusy++;
    end
    checks++;
    if (ndone !== 0 || nbusy !== 0)
      begin errors++; $display("[TB] FAIL busy_start_queued got done=%0d busy=%0d want 0/0", ndone, nbusy); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, ndone, nbusy;
    logic ch;
    launch(5555);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0 || bus.bcd_register !== 16'h0000)
      begin errors++; $display("[TB] FAIL reset_mid got busy=%b done=%b ovf=%b bcd=%h want 0/0/0/0000", bus.busy, bus.done, bus.overflow, bus.bcd_register); end
    ndone = 0;
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) nbusy++;
    end
    checks++;
    if (ndone !== 0 || nbusy !== 0)
      begin errors++; $display("[TB] FAIL reset_mid_abort got done=%0d busy=%0d want 0/0", ndone, nbusy); end
    launch(5555);
    wait_done(lat, bc, ch);
    checks++;
    if (lat !== 15 || bus.bcd_register !== 16'h5555)
      begin errors++; $display("[TB] FAIL reset_mid_restart got %h lat %0d want 5555 lat 15", bus.bcd_register, lat); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic ch;
    logic [15:0] exp_bcd;
    logic exp_ovf;
    for (int v = 0; v <= 16383; v = (v == 16371) ? 16383 : v + 17) begin
      exp_bcd = expected_bcd(v);
      exp_ovf = (v > 9999);
      launch(v);
      wait_done(lat, bc, ch);
      checks++;
      if (lat !== 15 || bus.bcd_register !== exp_bcd || bus.overflow !== exp_ovf)
        begin errors++; $display("[TB] FAIL sweep_%0d got %h/%b lat %0d want %h/%b lat 15", v, bus.bcd_register, bus.overflow, lat, exp_bcd, exp_ovf); end
      checks++;
      if (ch !== 1'b0) begin errors++; $display("[TB] FAIL sweep_hold_%0d got changed=%b want 0", v, ch); end
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (bus.bcd_register[4*d +: 4] > 4'd9)
          begin errors++; $display("[TB] FAIL sweep_digit_%0d_%0d got %h want <=9", v, d, bus.bcd_register[4*d +: 4]); end
      end
      if (v == 16383) break;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_boundary();
    test_start_while_busy();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
